load_unit: RTL and testbench

Multi-cycle RV32I load unit for LB/LH/LW/LBU/LHU. It is the read-side counterpart of the S-type store path.
- Computes the effective address and issues a word read to the shared 256-word data RAM.
- Waits a fixed RAM latency, then extracts the byte/halfword and sign- or zero-extends it.
- Drives one register-file writeback strobe per accepted instruction.
- Sits beside the store unit on the RAM port; the core sequencer starts it and stalls on oBUSY.

---
 rtl/load_unit.sv | 166 ++++++++++++++++
 tb/tb_load_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// Multi-cycle RV32I load unit (LB/LH/LW/LBU/LHU) issuing word reads to a fixed-latency data RAM.
// Optional macro LOAD_MISALIGN_TRAP_EN adds a FAULT state that traps misaligned LH/LHU/LW.
module load_unit #(
  parameter int RAM_LATENCY = 1,
  parameter int ADDR_W      = 8
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iSTART,
  input  logic [31:0]       iIR,
  input  logic [31:0]       iREG_OUT1,
  output logic [4:0]        oRS1,
  output logic [4:0]        oRD,
  output logic [31:0]       oREG_IN,
  output logic              oREG_WE,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oRAM_CE,
  output logic              oRAM_RD,
  output logic              oRAM_WR,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  input  logic [31:0]       iRAM_DATA,
  output logic              oMISALIGN
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
`ifdef LOAD_MISALIGN_TRAP_EN
    WB    = 2'd2,
    FAULT = 2'd3
`else
    WB    = 2'd2
`endif
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [31:0]        addr;
  logic [2:0]         funct3_in;
  logic               legal_in;
  logic [2:0]         funct3;
  logic [1:0]         offset;
  logic [CNT_W-1:0]   cnt;
  logic               last_read;
  logic               done_next;

  assign oRS1      = iIR[19:15];
  assign oRAM_WR   = 1'b0;
  assign oBUSY     = (state != IDLE);
  assign funct3_in = iIR[14:12];
  assign addr      = iREG_OUT1 + {{20{iIR[31]}}, iIR[31:20]};
  assign last_read = (cnt == CNT_W'(RAM_LATENCY - 1));

  always_comb begin
    legal_in = 1'b0;
    case (funct3_in)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal_in = 1'b1;
      default:                      legal_in = 1'b0;
    endcase
  end

`ifdef LOAD_MISALIGN_TRAP_EN
  logic misalign_in;
  assign misalign_in = (((funct3_in == 3'd1) || (funct3_in == 3'd5)) && addr[0]) ||
                       ((funct3_in == 3'd2) && (addr[1:0] != 2'b00));
`endif

  // Byte/halfword lane select followed by sign or zero extension.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [31:0] bsh;
    logic [31:0] hsh;
    logic [7:0]  b;
    logic [15:0] h;
    bsh = word >> {off, 3'b000};
    hsh = word >> {off[1], 4'b0000};
    b   = bsh[7:0];
    h   = hsh[15:0];
    case (f3)
      3'd0:    extract = {{24{b[7]}}, b};
      3'd1:    extract = {{16{h[15]}}, h};
      3'd2:    extract = word;
      3'd4:    extract = {24'd0, b};
      3'd5:    extract = {16'd0, h};
      default: extract = 32'd0;
    endcase
  endfunction

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (iSTART) begin
          if (!legal_in) next_state = WB;
`ifdef LOAD_MISALIGN_TRAP_EN
          else if (misalign_in) next_state = FAULT;
`endif
          else next_state = READ;
        end
      end
      READ:    if (last_read) next_state = WB;
      WB:      next_state = IDLE;
`ifdef LOAD_MISALIGN_TRAP_EN
      FAULT:   next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
    done_next = (next_state == WB);
`ifdef LOAD_MISALIGN_TRAP_EN
    if (next_state == FAULT) done_next = 1'b1;
`endif
  end

  // All outputs are registered off the upcoming state so they line up with it.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oRD       <= '0;
      oREG_IN   <= '0;
      oREG_WE   <= 1'b0;
      oDONE     <= 1'b0;
      oRAM_CE   <= 1'b0;
      oRAM_RD   <= 1'b0;
      oRAM_ADDR <= '0;
      funct3    <= '0;
      offset    <= '0;
      cnt       <= '0;
    end else begin
      oRAM_CE <= (next_state == READ);
      oRAM_RD <= (next_state == READ);
      oDONE   <= done_next;
      oREG_WE <= (state == READ) && last_read && (oRD != 5'd0);
      if ((state == IDLE) && iSTART) begin
        funct3    <= funct3_in;
        oRD       <= iIR[11:7];
        offset    <= addr[1:0];
        oRAM_ADDR <= addr[ADDR_W+1:2];
        cnt       <= '0;
      end else if (state == READ) begin
        cnt <= cnt + 1'b1;
      end
      if ((state == READ) && last_read)
        oREG_IN <= extract(iRAM_DATA, funct3, offset);
      else if ((state == IDLE) && iSTART && !legal_in)
        oREG_IN <= '0;
    end
  end

`ifdef LOAD_MISALIGN_TRAP_EN
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) oMISALIGN <= 1'b0;
    else         oMISALIGN <= (next_state == FAULT);
  end
`else
  assign oMISALIGN = 1'b0;
`endif

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: two instances (RAM_LATENCY 1 and 3) share stimulus and are checked per cycle
// against a behavioural model of the load semantics.
module tb_load_unit;

  localparam int NCAP = 7;
`ifdef LOAD_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // {ce, rd strobe, wr strobe, done, we, busy, misalign}, ram addr, rd, writeback data
  typedef struct packed {
    logic [6:0]  ctl;
    logic [7:0]  addr;
    logic [4:0]  rd;
    logic [31:0] data;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ir = '0;
  logic [31:0] rs1 = '0;

  logic [4:0]  rs1_idx1, rd1, rs1_idx3, rd3;
  logic [31:0] reg_in1, reg_in3, data1, data3;
  logic        we1, busy1, done1, ce1, rds1, wr1, mis1;
  logic        we3, busy3, done3, ce3, rds3, wr3, mis3;
  logic [7:0]  addr1, addr3;

  logic [31:0] mem [256];
  int          cnt1, cnt3;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  load_unit #(.RAM_LATENCY(1), .ADDR_W(8)) dut1 (
    .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iIR(ir), .iREG_OUT1(rs1),
    .oRS1(rs1_idx1), .oRD(rd1), .oREG_IN(reg_in1), .oREG_WE(we1), .oBUSY(busy1),
    .oDONE(done1), .oRAM_CE(ce1), .oRAM_RD(rds1), .oRAM_WR(wr1), .oRAM_ADDR(addr1),
    .iRAM_DATA(data1), .oMISALIGN(mis1)
  );

  load_unit #(.RAM_LATENCY(3), .ADDR_W(8)) dut3 (
    .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iIR(ir), .iREG_OUT1(rs1),
    .oRS1(rs1_idx3), .oRD(rd3), .oREG_IN(reg_in3), .oREG_WE(we3), .oBUSY(busy3),
    .oDONE(done3), .oRAM_CE(ce3), .oRAM_RD(rds3), .oRAM_WR(wr3), .oRAM_ADDR(addr3),
    .iRAM_DATA(data3), .oMISALIGN(mis3)
  );

  // RAM models: data is only correct in the last strobe cycle, garbage otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1 <= 0;
      cnt3 <= 0;
    end else begin
      cnt1 <= rds1 ? cnt1 + 1 : 0;
      cnt3 <= rds3 ? cnt3 + 1 : 0;
    end
  end
  assign data1 = (rds1 && cnt1 == 0) ? mem[addr1] : ~mem[addr1];
  assign data3 = (rds3 && cnt3 == 2) ? mem[addr3] : ~mem[addr3];

  function automatic snap_t obs1();
    obs1 = {ce1, rds1, wr1, done1, we1, busy1, mis1, addr1, rd1, reg_in1};
  endfunction

  function automatic snap_t obs3();
    obs3 = {ce3, rds3, wr3, done3, we3, busy3, mis3, addr3, rd3, reg_in3};
  endfunction

  function automatic logic [31:0] enc(input logic [11:0] imm, input logic [2:0] f3,
                                      input logic [4:0] rd_v);
    enc = {imm, 5'd1, f3, rd_v, 7'b0000011};
  endfunction

  // Expected outputs in cycle k (k=1 is the cycle after the accepting edge).
  function automatic snap_t model(input logic [31:0] ir_v, input logic [31:0] rs1_v,
                                  input int lat, input int k);
    logic [31:0] a, w, b, h, val;
    logic [2:0]  f3;
    logic [4:0]  rd_v;
    bit          legal, fault, ce;
    int          dk;
    a     = rs1_v + {{20{ir_v[31]}}, ir_v[31:20]};
    f3    = ir_v[14:12];
    rd_v  = ir_v[11:7];
    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    fault = TRAP_EN && legal &&
            ((((f3 == 1) || (f3 == 5)) && a[0]) || ((f3 == 2) && (a[1:0] != 0)));
    w = mem[a[9:2]];
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0:    val = (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'd1:    val = (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'd2:    val = w;
      3'd4:    val = b;
      3'd5:    val = h;
      default: val = 32'd0;
    endcase
    dk = (!legal || fault) ? 1 : lat + 1;
    ce = legal && !fault && (k <= lat);
    model.ctl  = {ce, ce, 1'b0, k == dk, (k == dk) && legal && !fault && (rd_v != 0),
                  k <= dk, fault && (k == 1)};
    model.addr = a[9:2];
    model.rd   = rd_v;
    model.data = val;
  endfunction

  task automatic test_reset();
    snap_t o1, o3;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    o1 = obs1();
    o3 = obs3();
    n_checks++;
    if (o1 !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_lat1 got %h expected 0", o1);
    end
    n_checks++;
    if (o3 !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_lat3 got %h expected 0", o3);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_loads(input string name, input logic [31:0] ir_v, input logic [31:0] rs1_v,
                            input bit poke, input bit use_const, input logic [31:0] cval);
    snap_t t1 [NCAP+1];
    snap_t t3 [NCAP+1];
    snap_t e, o;
    int    lat;
    @(negedge clk);
    ir    = ir_v;
    rs1   = rs1_v;
    start = 1'b1;
    #1;
    n_checks++;
    if (rs1_idx1 !== ir_v[19:15] || rs1_idx3 !== ir_v[19:15]) begin
      n_fail++;
      $display("[TB] FAIL %s rs1_idx got %0d/%0d expected %0d", name, rs1_idx1, rs1_idx3,
               ir_v[19:15]);
    end
    @(posedge clk);
    for (int k = 1; k <= NCAP; k++) begin
      @(negedge clk);
      t1[k] = obs1();
      t3[k] = obs3();
      if (k == 1) begin
        start = poke;
        if (poke) begin
          ir  = ir_v ^ 32'h0000_0F80;
          rs1 = ~rs1_v;
        end
      end else begin
        start = 1'b0;
      end
    end
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      for (int k = 1; k <= NCAP; k++) begin
        e = model(ir_v, rs1_v, lat, k);
        o = (d == 0) ? t1[k] : t3[k];
        n_checks++;
        if (o.ctl !== e.ctl) begin
          n_fail++;
          $display("[TB] FAIL %s lat%0d cycle %0d ctl got %b expected %b", name, lat, k,
                   o.ctl, e.ctl);
        end
        n_checks++;
        if (o.addr !== e.addr) begin
          n_fail++;
          $display("[TB] FAIL %s lat%0d cycle %0d addr got %h expected %h", name, lat, k,
                   o.addr, e.addr);
        end
        if (e.ctl[3] && !e.ctl[0]) begin
          n_checks++;
          if (o.rd !== e.rd) begin
            n_fail++;
            $display("[TB] FAIL %s lat%0d rd got %0d expected %0d", name, lat, o.rd, e.rd);
          end
          n_checks++;
          if (o.data !== e.data) begin
            n_fail++;
            $display("[TB] FAIL %s lat%0d data got %h expected %h", name, lat, o.data, e.data);
          end
          if (use_const) begin
            n_checks++;
            if (o.data !== cval) begin
              n_fail++;
              $display("[TB] FAIL %s lat%0d const data got %h expected %h", name, lat,
                       o.data, cval);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    snap_t o1, o3;
    @(negedge clk);
    ir    = enc(12'h000, 3'd2, 5'd5);
    rs1   = 32'h40;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      o1 = obs1();
      o3 = obs3();
      n_checks++;
      if (o1 !== '0 || o3 !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_mid step %0d got %h / %h expected 0", k, o1, o3);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    test_loads("post_reset_lw", enc(12'h000, 3'd2, 5'd6), 32'h40, 1'b0, 1'b1, 32'h80F17F22);
  endtask

  task automatic test_back_to_back();
    snap_t o;
    int    lat, p;
    bit    exp_ce, exp_done;
    @(negedge clk);
    ir    = enc(12'h000, 3'd2, 5'd7);
    rs1   = 32'h40;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        lat      = (d == 0) ? 1 : 3;
        o        = (d == 0) ? obs1() : obs3();
        p        = k % (lat + 2);
        exp_done = (p == lat + 1);
        exp_ce   = (p >= 1) && (p <= lat);
        n_checks++;
        if ({o.ctl[6], o.ctl[3], o.ctl[2]} !== {exp_ce, exp_done, exp_done}) begin
          n_fail++;
          $display("[TB] FAIL b2b lat%0d cycle %0d ce/done/we got %b expected %b", lat, k,
                   {o.ctl[6], o.ctl[3], o.ctl[2]}, {exp_ce, exp_done, exp_done});
        end
        if (exp_done) begin
          n_checks++;
          if (o.data !== 32'h80F17F22) begin
            n_fail++;
            $display("[TB] FAIL b2b lat%0d cycle %0d data got %h expected 80f17f22", lat, k,
                     o.data);
          end
        end
      end
      if (k == 12) start = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random(input int n);
    logic [31:0] ir_v, rs1_v;
    for (int i = 0; i < n; i++) begin
      ir_v  = enc(12'($urandom), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      rs1_v = $urandom;
      test_loads("random", ir_v, rs1_v, (i % 5) == 0, 1'b0, 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[16] = 32'h80F17F22;
    test_reset();
    test_loads("lw_basic", enc(12'h000, 3'd2, 5'd5), 32'h40, 1'b0, 1'b1, 32'h80F17F22);
    test_loads("lb_off1",  enc(12'h001, 3'd0, 5'd5), 32'h40, 1'b0, 1'b1, 32'h0000007F);
    test_loads("lb_off3",  enc(12'h003, 3'd0, 5'd5), 32'h40, 1'b0, 1'b1, 32'hFFFFFF80);
    test_loads("lbu_off3", enc(12'h003, 3'd4, 5'd5), 32'h40, 1'b0, 1'b1, 32'h00000080);
    test_loads("lh_off2",  enc(12'h002, 3'd1, 5'd5), 32'h40, 1'b0, 1'b1, 32'hFFFF80F1);
    test_loads("lhu_off2", enc(12'h002, 3'd5, 5'd5), 32'h40, 1'b0, 1'b1, 32'h000080F1);
    test_loads("lw_neg",   enc(12'hFFC, 3'd2, 5'd5), 32'h44, 1'b0, 1'b1, 32'h80F17F22);
    test_loads("lw_x0",    enc(12'h000, 3'd2, 5'd0), 32'h40, 1'b1, 1'b1, 32'h80F17F22);
    test_loads("illegal3", enc(12'h000, 3'd3, 5'd5), 32'h40, 1'b1, 1'b1, 32'h00000000);
    test_loads("lw_mis",   enc(12'h000, 3'd2, 5'd5), 32'h42, 1'b0, 1'b1, 32'h80F17F22);
    test_loads("lh_mis",   enc(12'h000, 3'd1, 5'd5), 32'h41, 1'b0, 1'b1, 32'h00007F22);
    test_reset_mid();
    test_back_to_back();
    test_random(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
